// File: rtl/rolling_message_scroller_pkg.sv
// Shared types and helpers for the rolling message scroller.
package rolling_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned WINDOW   = 8;
  // Wide enough for any legal buffer index and for a length up to 32.
  localparam int unsigned IDX_W    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] mod_inc(input logic [IDX_W-1:0] x,
                                               input logic [IDX_W-1:0] lim);
    logic [IDX_W-1:0] nx;
    nx = x + IDX_W'(1);
    return (nx >= lim) ? '0 : nx;
  endfunction

  function automatic logic [IDX_W-1:0] mod_dec(input logic [IDX_W-1:0] x,
                                               input logic [IDX_W-1:0] lim);
    return (x == '0) ? lim - IDX_W'(1) : x - IDX_W'(1);
  endfunction

endpackage

// File: rtl/rolling_message_scroller_tick_prescaler.sv
// Free-running step prescaler; tick marks the last cycle of each TICK_DIV period.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned      CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Counter freezes while en is low; clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Combinational so the head advances on the same edge the counter wraps.
  assign tick = en && !clr && (cnt == CNT_MAX);

endmodule

// File: rtl/rolling_message_scroller.sv
// Scrolls an 8-digit window through a nibble message buffer for the display driver.
// Optional right-scroll support via `define ROLL_DIR_EN (adds the dir port).
module rolling_message_scroller
  import rolling_pkg::*;
#(
  parameter int unsigned MSG_DEPTH = 16,
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned PTR_W     = $clog2(MSG_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [PTR_W-1:0]    wr_addr,
  input  logic [NIBBLE_W-1:0] wr_data,
  output logic                wr_ready,
  input  logic [PTR_W:0]      len,
  input  logic                start,
  input  logic                stop,
  input  logic                hold,
`ifdef ROLL_DIR_EN
  input  logic                dir,
`endif
  output logic [NIBBLE_W-1:0] d0,
  output logic [NIBBLE_W-1:0] d1,
  output logic [NIBBLE_W-1:0] d2,
  output logic [NIBBLE_W-1:0] d3,
  output logic [NIBBLE_W-1:0] d4,
  output logic [NIBBLE_W-1:0] d5,
  output logic [NIBBLE_W-1:0] d6,
  output logic [NIBBLE_W-1:0] d7,
  output logic                step,
  output logic                busy
);

  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(MSG_DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic [NIBBLE_W-1:0] mem      [MSG_DEPTH];
  logic [NIBBLE_W-1:0] win_q    [WINDOW];
  logic [NIBBLE_W-1:0] window_c [WINDOW];
  logic [PTR_W:0]      len_q;
  logic [PTR_W-1:0]    head;
  logic [IDX_W-1:0]    idx;
  logic                tick;
  logic                step_pend;
  logic                right_c;
  logic                start_acc_c;
  logic                clr_c;
  logic                run_en_c;
  logic                wr_acc_c;
  logic                busy_nxt_c;
  logic                wr_ready_nxt_c;

`ifdef ROLL_DIR_EN
  assign right_c = dir;
`else
  assign right_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; stop overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop && (len != '0)) state_nxt = RUN;
      RUN:     if (stop) state_nxt = IDLE;
               else if (hold) state_nxt = HOLD;
      HOLD:    if (stop) state_nxt = IDLE;
               else if (!hold) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes and next values of the registered status outputs
  always_comb begin
    start_acc_c    = 1'b0;
    clr_c          = 1'b0;
    run_en_c       = 1'b0;
    wr_acc_c       = 1'b0;
    busy_nxt_c     = 1'b0;
    wr_ready_nxt_c = 1'b1;
    start_acc_c    = (state == IDLE) && (state_nxt == RUN);
    clr_c          = start_acc_c || stop;
    run_en_c       = (state == RUN) && !stop;
    wr_acc_c       = wr_en && (state == IDLE) && ({1'b0, wr_addr} < DEPTH_L);
    busy_nxt_c     = (state_nxt != IDLE);
    wr_ready_nxt_c = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      busy     <= busy_nxt_c;
      wr_ready <= wr_ready_nxt_c;
    end
  end

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_en_c),
    .clr   (clr_c),
    .tick  (tick)
  );

  // Message storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MSG_DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc_c) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Length and scroll position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= DEPTH_L;
      head  <= '0;
    end else if (start_acc_c) begin
      len_q <= (len > DEPTH_L) ? DEPTH_L : len;
      head  <= '0;
    end else if (stop) begin
      head  <= '0;
    end else if (tick) begin
      head  <= right_c ? PTR_W'(mod_dec(IDX_W'(head), IDX_W'(len_q)))
                       : PTR_W'(mod_inc(IDX_W'(head), IDX_W'(len_q)));
    end
  end

  // Walk the buffer from head with wrap at len_q; short messages repeat
  always_comb begin
    idx = IDX_W'(head);
    for (int unsigned k = 0; k < WINDOW; k++) begin
      window_c[k] = mem[PTR_W'(idx)];
      idx         = mod_inc(idx, IDX_W'(len_q));
    end
  end

  // step is delayed one extra cycle so it lines up with the refreshed window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < WINDOW; k++) win_q[k] <= '0;
      step_pend <= 1'b0;
      step      <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < WINDOW; k++) win_q[k] <= window_c[k];
      step_pend <= tick;
      step      <= step_pend;
    end
  end

  assign d0 = win_q[0];
  assign d1 = win_q[1];
  assign d2 = win_q[2];
  assign d3 = win_q[3];
  assign d4 = win_q[4];
  assign d5 = win_q[5];
  assign d6 = win_q[6];
  assign d7 = win_q[7];

endmodule

// File: doc/rolling_message_scroller.md
# rolling_message_scroller

Upstream feeder for the 8-digit multiplexed seven-segment driver. Holds a hex-nibble message of up to MSG_DEPTH digits, written over a simple write port. In RUN it rotates an 8-digit window through the message at a prescaled step rate. Its eight registered nibble outputs connect directly to the display driver's eight digit inputs.

## Interface
- MSG_DEPTH, 16: message buffer depth in digits; legal 8..32.
- TICK_DIV, 25_000_000: clk cycles per scroll step; legal ≥2.
- PTR_W, $clog2(MSG_DEPTH): derived; not overridden.
- clk  in  1  system clock (same domain as display driver).
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe; accepted only when wr_ready=1.
- wr_addr  in  PTR_W  buffer address.
- wr_data  in  4  nibble to store.
- wr_ready  out  1  high only in IDLE.
- len  in  PTR_W+1  message length; sampled on accepted start.
- start  in  1  one-cycle command: IDLE→RUN.
- stop  in  1  one-cycle command: any state→IDLE.
- hold  in  1  level; freezes scrolling while high.
- dir  in  1  only with ROLL_DIR_EN: 0=left, 1=right.
- d0..d7  out  4 each  window digits; d0 is leftmost.
- step  out  1  one-cycle pulse coincident with a window advance.
- busy  out  1  high in RUN or HOLD.

## Operation
- Storage: mem[MSG_DEPTH] of 4-bit nibbles, cleared to 0 on reset. A write in IDLE with wr_en=1 sets mem[wr_addr]=wr_data at the edge. Writes outside IDLE and writes with wr_addr≥MSG_DEPTH are dropped.
- Registers: len_q (reset MSG_DEPTH); head (reset 0); prescaler cnt (reset 0).
- Window: each edge, d_k ← mem[(head+k) mod len_q] for k=0..7. When len_q<8 the message repeats across the window.
- FSM states: IDLE, RUN, HOLD.
  - IDLE→RUN on start with 1≤len≤MSG_DEPTH. Loads len_q=len, head=0, cnt=0.
  - start with len=0: ignored. start with len>MSG_DEPTH: len_q clamped to MSG_DEPTH.
  - RUN→HOLD when hold=1. HOLD→RUN when hold=0. cnt is frozen in HOLD, not cleared.
  - RUN/HOLD→IDLE on stop. Clears head and cnt; len_q retained.
  - start and stop in the same cycle: stop wins. start outside IDLE: ignored.
- Step: in RUN, cnt counts 0..TICK_DIV-1. On cnt==TICK_DIV-1, cnt←0 and head←(head+1) mod len_q (left scroll). Wrap from len_q-1 to 0 is seamless.
- Reset values: d0..d7=0, step=0, busy=0, wr_ready=1.

## Timing
- Write→output latency: 1 cycle. A write at edge N appears on d_k at edge N+1 if its address is in the window.
- Step latency: head updates at edge N. step=1 and the new window are both valid after edge N+1, i.e. step is aligned with the changed outputs.
- Step period is exactly TICK_DIV cycles in uninterrupted RUN. hold stretches it by the number of held cycles.
- rst_n low mid-run: all state returns to reset values immediately (asynchronous). Release takes effect at the next clk edge.
- busy and wr_ready change at the edge where the state changes.

## Configuration
- ROLL_DIR_EN defined: dir port present. dir=1 gives head←(head+len_q-1) mod len_q on each step (right scroll). dir is sampled on the step cycle.
- ROLL_DIR_EN undefined: no dir port; left scroll only.

## Structure
- Shared package rolling_pkg:
  - NIBBLE_W=4, WINDOW=8.
  - state enum (IDLE, RUN, HOLD).
  - modular-increment helper function.
- Sub-module tick_prescaler (parameter TICK_DIV; inputs clk, rst_n, en, clr; output tick). Instantiated once.
- Top holds mem, the FSM, head, and the window register.

## Test plan
- Reset, no writes: d0..d7=0, wr_ready=1, busy=0, step never pulses.
- TICK_DIV=4. Write mem[i]=i for i=0..15, start len=16 → first step 4 cycles after start. Window then reads 1,2,…,8; after 16 steps it is 0..7 again.
- len=3, mem={A,B,C}, start → initial window A,B,C,A,B,C,A,B. After one step: B,C,A,B,C,A,B,C.
- hold high for 10 cycles mid-count → that step period is 14 cycles. Head unchanged during hold; busy stays 1.
- start and stop in the same cycle in IDLE → stays IDLE. stop during RUN → head=0 and the window shows mem[0..7 mod len_q] next cycle. A write during RUN is not stored.
- With ROLL_DIR_EN, dir=1, len=16, mem[i]=i → after the first step d0=F, d1=0, …, d7=6.
